// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the add_seq multi-cycle adder.
package add_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int calc_nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // The slice counter needs at least one bit even when a single slice covers the word.
   function automatic int calc_kw(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/add_seq_chunk.sv
// CHUNK-bit ripple adder built from full_adder cells; also exposes the carry
// into its MSB so the top can form the two's-complement overflow flag.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module add_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum[i]),
         .co (c[i+1])
      );
   end

   assign co    = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/add_seq.sv
// Multi-cycle adder: one CHUNK-bit slice per clock through a shared add_chunk.
// Define ADD_SEQ_SUB_EN to add the `sub` port and subtraction support.
module add_seq
   import add_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             c_in,
`ifdef ADD_SEQ_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
   localparam int KW     = calc_kw(NCHUNK);
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_width
      $error("add_seq: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_t           state, state_next;
   logic [WIDTH-1:0] x_reg, y_reg, acc, acc_next;
   logic [WIDTH-1:0] y_load;
   logic             c_load;
   logic             carry;
   logic [KW-1:0]    k;
   logic [CHUNK-1:0] chunk_sum;
   logic             chunk_co, chunk_cmsb;
   logic             last_slice;

   // Subtraction is x + ~y + ~borrow, so the inversion is folded into the operand load.
`ifdef ADD_SEQ_SUB_EN
   assign y_load = sub ? ~y : y;
   assign c_load = sub ? ~c_in : c_in;
`else
   assign y_load = y;
   assign c_load = c_in;
`endif

   add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (x_reg[int'(k)*CHUNK +: CHUNK]),
      .b     (y_reg[int'(k)*CHUNK +: CHUNK]),
      .ci    (carry),
      .sum   (chunk_sum),
      .co    (chunk_co),
      .c_msb (chunk_cmsb)
   );

   assign last_slice = (k == K_LAST);
   assign in_ready   = (state == IDLE) && !rst;
   assign out_valid  = (state == DONE);

   always_comb begin
      acc_next = acc;
      acc_next[int'(k)*CHUNK +: CHUNK] = chunk_sum;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = RUN;
         RUN:     if (last_slice) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Results are loaded only on the final slice so partial sums never reach s.
   always_ff @(posedge clk) begin
      if (rst) begin
         k     <= '0;
         carry <= 1'b0;
         s     <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg <= x;
                  y_reg <= y_load;
                  carry <= c_load;
                  k     <= '0;
               end
            end
            RUN: begin
               acc   <= acc_next;
               carry <= chunk_co;
               k     <= k + KW'(1);
               if (last_slice) begin
                  s     <= acc_next;
                  c_out <= chunk_co;
                  ovf   <= chunk_cmsb ^ chunk_co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_add_seq.sv
// Directed bench for add_seq (WIDTH=16, CHUNK=4) with hand-computed results.
module tb_add_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x, y;
   logic        c_in;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] s;
   logic        c_out;
   logic        ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   add_seq #(.WIDTH(16), .CHUNK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .c_in      (c_in),
`ifdef ADD_SEQ_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Offers one operand beat in IDLE and returns 1 ns after the accepting edge.
   task automatic applyStimulus(input logic [15:0] xa, input logic [15:0] yb,
                                input logic ci, input logic sb);
      x        = xa;
      y        = yb;
      c_in     = ci;
      sub      = sb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitResult(input string tag);
      for (int i = 0; i < 20 && !out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput(tag, 32'(out_valid), 32'd1);
   endtask

   task automatic releaseResult();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      y         = '0;
      c_in      = 1'b0;
      sub       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_s", 32'(s), 32'h0);
      checkOutput("rst_c_out", 32'(c_out), 32'd0);
      checkOutput("rst_ovf", 32'(ovf), 32'd0);
      checkOutput("rst_in_ready_low", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

      $display("[TB] plain add with latency check");
      applyStimulus(16'h1234, 16'h0FFF, 1'b0, 1'b0);
      checkOutput("lat_edge0", 32'(out_valid), 32'd0);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("lat_edge%0d", i), 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      checkOutput("lat_edge4", 32'(out_valid), 32'd1);
      checkOutput("add_s", 32'(s), 32'h2233);
      checkOutput("add_c_out", 32'(c_out), 32'd0);
      checkOutput("add_ovf", 32'(ovf), 32'd0);
      checkOutput("done_in_ready", 32'(in_ready), 32'd0);
      releaseResult();
      checkOutput("add_release_valid", 32'(out_valid), 32'd0);
      checkOutput("add_release_ready", 32'(in_ready), 32'd1);

      $display("[TB] unsigned wrap");
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      waitResult("wrap_timeout");
      checkOutput("wrap_s", 32'(s), 32'h0000);
      checkOutput("wrap_c_out", 32'(c_out), 32'd1);
      checkOutput("wrap_ovf", 32'(ovf), 32'd0);
      releaseResult();

      $display("[TB] signed overflow");
      applyStimulus(16'h7FFF, 16'h0000, 1'b1, 1'b0);
      waitResult("ovf_timeout");
      checkOutput("ovf_s", 32'(s), 32'h8000);
      checkOutput("ovf_c_out", 32'(c_out), 32'd0);
      checkOutput("ovf_ovf", 32'(ovf), 32'd1);
      releaseResult();

      $display("[TB] backpressure");
      applyStimulus(16'h00FF, 16'h0101, 1'b0, 1'b0);
      waitResult("bp_timeout");
      x        = 16'hAAAA;
      y        = 16'h5555;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
         checkOutput($sformatf("bp_s%0d", i), 32'(s), 32'h0200);
         checkOutput($sformatf("bp_c_out%0d", i), 32'(c_out), 32'd0);
         checkOutput($sformatf("bp_ovf%0d", i), 32'(ovf), 32'd0);
         checkOutput($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      releaseResult();
      checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
      checkOutput("bp_release_ready", 32'(in_ready), 32'd1);

      $display("[TB] reset during second slice");
      applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_s", 32'(s), 32'h0);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_idle", 32'(in_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("mid_rst_quiet%0d", i), 32'(out_valid), 32'd0);
      end
      applyStimulus(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
      waitResult("fresh_timeout");
      checkOutput("fresh_s", 32'(s), 32'h1001);
      checkOutput("fresh_c_out", 32'(c_out), 32'd0);
      checkOutput("fresh_ovf", 32'(ovf), 32'd0);
      releaseResult();

`ifdef ADD_SEQ_SUB_EN
      $display("[TB] subtract");
      applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
      waitResult("sub_timeout");
      checkOutput("sub_s", 32'(s), 32'hFFFE);
      checkOutput("sub_c_out", 32'(c_out), 32'd0);
      checkOutput("sub_ovf", 32'(ovf), 32'd0);
      releaseResult();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
